irq_nest_dispatcher: RTL and testbench
======================================

Name: irq_nest_dispatcher

Overview:
- Sits between gp_interrupt_controller and one CPU core.
- Sequences interrupt delivery: offers the controller's highest-priority vector to the core and completes the take/ack handshake.
- Tracks nested in-service interrupts on a priority stack. Only a strictly higher-priority vector (lower number) preempts the current one.
- Signals the controller with irq_ack so the pending bit is cleared on the exact vector the core accepted.

Parameters:
- NEST_DEPTH, 4, maximum number of simultaneously in-service (nested) interrupts; range 1..8.
- VEC_W, 5, vector width; matches 32 interrupt sources.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- irq_req  input  1  controller: some enabled interrupt is pending
- irq_vector  input  VEC_W  controller: highest-priority pending vector (0 = highest)
- irq_ack  output  1  to controller: clear pending bit of irq_vector this cycle
- global_en  input  1  core global interrupt enable
- core_irq  output  1  interrupt offered to core
- core_vector  output  VEC_W  vector being offered
- core_take  input  1  core accepts the offered vector this cycle
- core_eoi  input  1  core end-of-interrupt; retires the top of stack
- in_service  output  1  stack non-empty
- cur_vector  output  VEC_W  top-of-stack vector; 0 when empty
- active_depth  output  4  number of stacked entries
- err_flags  output  2  sticky errors: [0] EOI with empty stack, [1] core_take while core_irq low
- err_clr  input  1  clears err_flags

Behaviour:
- Interface timing: one clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset values: state IDLE; stack empty; active_depth 0; core_irq, core_vector, cur_vector, in_service, err_flags all 0; irq_ack 0.
- Eligibility is combinational: elig = global_en & irq_req & (depth < NEST_DEPTH) & (depth == 0 | irq_vector < top).
- The FSM has two states, IDLE and OFFER.
- IDLE:
  - if elig, go to OFFER; register core_vector <= irq_vector and core_irq <= 1.
  - Latency: eligible request at cycle N gives core_irq high at N+1.
- OFFER: evaluate the following in priority order each cycle.
  1. Withdraw: if !elig, go to IDLE; core_irq <= 0. A core_take in this cycle is ignored and sets err_flags[1].
  2. Retarget: if elig and irq_vector != core_vector, core_vector <= irq_vector and stay in OFFER. A core_take in this cycle is ignored; no error is flagged.
  3. Accept: if elig and irq_vector == core_vector and core_take:
     - irq_ack = 1 combinationally in this cycle;
     - push core_vector onto the stack;
     - core_irq <= 0;
     - go to IDLE.
- irq_ack is asserted only in the Accept case and is never registered. The controller clears the bit at irq_vector, which equals core_vector in that cycle.
- core_take while core_irq = 0 is ignored and sets err_flags[1].
- core_eoi pops the top of the stack in any state.
  - EOI on an empty stack is ignored and sets err_flags[0].
  - EOI in the same cycle as Accept: pop the old top, then push the new vector. Net effect: top is replaced and depth is unchanged.
  - Eligibility for that cycle uses the pre-pop stack.
- Stack is a LIFO register array of NEST_DEPTH x VEC_W. cur_vector is the top entry, in_service = (depth != 0), and active_depth = depth. All three are registered and reflect the updated stack the cycle after a push or pop.
- Full stack: no new offer is made. elig is false, so an OFFER in progress withdraws.
- err_flags: set takes precedence over err_clr in the same cycle.
- Reset mid-OFFER or mid-nesting: everything returns to reset values. No irq_ack is issued and the controller pending bits are untouched.

Test Plan:
- Basic: irq_req=1, vector=7, global_en=1 at cycle 0 -> core_irq=1, core_vector=7 at cycle 1. core_take at cycle 3 -> irq_ack=1 in cycle 3; cycle 4: core_irq=0, cur_vector=7, active_depth=1. core_eoi -> active_depth=0, in_service=0.
- Nesting/preemption: vector 7 in service, then irq_vector=3 -> offered and accepted, depth=2, cur_vector=3. Then irq_vector=9 -> no core_irq. EOI twice -> depth 0, and vector 9 is offered one cycle later.
- Retarget: OFFER of vector 12, irq_vector changes to 4 -> core_vector=4 next cycle. core_take in the mismatch cycle gives no irq_ack; a take one cycle later acks vector 4.
- Withdraw: OFFER of vector 5, global_en drops -> core_irq=0 next cycle with no irq_ack. A simultaneous core_take sets err_flags[1]. err_clr -> err_flags=0.
- Full/underflow: NEST_DEPTH=4 filled with 20,15,10,2; irq_vector=1 pending -> no offer. EOI five times -> depth 0, err_flags[0]=1.
- Simultaneous: stack {7}, Accept of vector 3 with core_eoi in the same cycle -> depth stays 1, cur_vector=3. rst_n=0 mid-OFFER -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/irq_nest_dispatcher_if.sv
// Signal bundle between the interrupt controller / CPU core and the nesting dispatcher.
// master = dispatcher side, slave = controller and core side.
interface irq_nest_dispatcher_if #(
    parameter int VEC_W = 5
);
    logic             irq_req;
    logic [VEC_W-1:0] irq_vector;
    logic             irq_ack;
    logic             global_en;
    logic             core_irq;
    logic [VEC_W-1:0] core_vector;
    logic             core_take;
    logic             core_eoi;
    logic             in_service;
    logic [VEC_W-1:0] cur_vector;
    logic [3:0]       active_depth;
    logic [1:0]       err_flags;
    logic             err_clr;

    modport master (
        input  irq_req, irq_vector, global_en, core_take, core_eoi, err_clr,
        output irq_ack, core_irq, core_vector, in_service, cur_vector, active_depth, err_flags
    );

    modport slave (
        output irq_req, irq_vector, global_en, core_take, core_eoi, err_clr,
        input  irq_ack, core_irq, core_vector, in_service, cur_vector, active_depth, err_flags
    );
endinterface

// File: rtl/irq_nest_dispatcher.sv
// Offers the controller's best vector to the core, completes take/ack, and keeps a
// LIFO of nested in-service vectors so only strictly higher priority can preempt.
module irq_nest_dispatcher #(
    parameter int NEST_DEPTH = 4,
    parameter int VEC_W      = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    irq_nest_dispatcher_if.master bus
);
    localparam int         IDX_W     = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [3:0] DEPTH_MAX = 4'(NEST_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [VEC_W-1:0] stack_r [NEST_DEPTH];
    logic [3:0]       depth_r, depth_s;
    logic             core_irq_r, core_irq_s;
    logic [VEC_W-1:0] core_vector_r, core_vector_s;
    logic [VEC_W-1:0] cur_vector_r, cur_vector_s;
    logic             in_service_r;
    logic [1:0]       err_r, err_s;
    logic [VEC_W-1:0] top_s;
    logic [IDX_W-1:0] top_idx_s, below_idx_s, push_idx_s;
    logic             elig_s, accept_s, pop_s, take_err_s, eoi_err_s;

    // Stack pointers and eligibility, always judged against the pre-pop stack
    always_comb begin
        top_idx_s   = IDX_W'(depth_r - 4'd1);
        below_idx_s = IDX_W'(depth_r - 4'd2);
        push_idx_s  = IDX_W'(depth_r);
        if (depth_r != 4'd0) begin
            top_s = stack_r[top_idx_s];
        end else begin
            top_s = '0;
        end
        elig_s = bus.global_en & bus.irq_req & (depth_r < DEPTH_MAX) &
                 ((depth_r == 4'd0) | (bus.irq_vector < top_s));
    end

    // Offer FSM: withdraw beats retarget beats accept
    always_comb begin
        state_s       = state_r;
        core_irq_s    = core_irq_r;
        core_vector_s = core_vector_r;
        accept_s      = 1'b0;
        take_err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                take_err_s = bus.core_take;
                if (elig_s) begin
                    state_s       = OFFER;
                    core_irq_s    = 1'b1;
                    core_vector_s = bus.irq_vector;
                end else begin
                    state_s = IDLE;
                end
            end
            OFFER: begin
                if (!elig_s) begin
                    state_s    = IDLE;
                    core_irq_s = 1'b0;
                    take_err_s = bus.core_take;
                end else if (bus.irq_vector != core_vector_r) begin
                    core_vector_s = bus.irq_vector;
                end else if (bus.core_take) begin
                    accept_s   = 1'b1;
                    core_irq_s = 1'b0;
                    state_s    = IDLE;
                end else begin
                    state_s = OFFER;
                end
            end
            default: begin
                state_s    = IDLE;
                core_irq_s = 1'b0;
            end
        endcase
    end

    // Next stack depth, next top-of-stack and sticky error flags
    always_comb begin
        pop_s     = bus.core_eoi & (depth_r != 4'd0);
        eoi_err_s = bus.core_eoi & (depth_r == 4'd0);
        case ({accept_s, pop_s})
            2'b10:   depth_s = depth_r + 4'd1;
            2'b01:   depth_s = depth_r - 4'd1;
            default: depth_s = depth_r;
        endcase
        if (accept_s) begin
            cur_vector_s = core_vector_r;
        end else if (pop_s && (depth_r > 4'd1)) begin
            cur_vector_s = stack_r[below_idx_s];
        end else if (pop_s) begin
            cur_vector_s = '0;
        end else begin
            cur_vector_s = top_s;
        end
        if (bus.err_clr) begin
            err_s = {take_err_s, eoi_err_s};
        end else begin
            err_s = err_r | {take_err_s, eoi_err_s};
        end
    end

    // State, offer and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            depth_r       <= 4'd0;
            core_irq_r    <= 1'b0;
            core_vector_r <= '0;
            cur_vector_r  <= '0;
            in_service_r  <= 1'b0;
            err_r         <= 2'b00;
        end else begin
            state_r       <= state_s;
            depth_r       <= depth_s;
            core_irq_r    <= core_irq_s;
            core_vector_r <= core_vector_s;
            cur_vector_r  <= cur_vector_s;
            in_service_r  <= (depth_s != 4'd0);
            err_r         <= err_s;
        end
    end

    // LIFO storage; EOI together with accept overwrites the old top in place
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stack_r[i] <= '0;
            end
        end else if (accept_s && pop_s) begin
            stack_r[top_idx_s] <= core_vector_r;
        end else if (accept_s) begin
            stack_r[push_idx_s] <= core_vector_r;
        end else begin
            stack_r <= stack_r;
        end
    end

    assign bus.irq_ack      = accept_s & rst_n;
    assign bus.core_irq     = core_irq_r;
    assign bus.core_vector  = core_vector_r;
    assign bus.cur_vector   = cur_vector_r;
    assign bus.in_service   = in_service_r;
    assign bus.active_depth = depth_r;
    assign bus.err_flags    = err_r;
endmodule

// File: tb/tb_irq_nest_dispatcher.sv
// Bench for irq_nest_dispatcher: pending-bit controller model, queue-based reference
// model, directed scenarios and a randomized run.
module tb_irq_nest_dispatcher;
    localparam int ND = 4;
    localparam int VW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    irq_nest_dispatcher_if #(.VEC_W(VW)) bus ();
    irq_nest_dispatcher #(.NEST_DEPTH(ND), .VEC_W(VW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] pending;
    int checks = 0;
    int failures = 0;
    bit   m_offer;
    int   m_vec;
    int   m_q[$];
    bit [1:0] m_err;
    bit   exp_ack, obs_ack;

    task automatic drive_ctrl();
        int v = 0;
        for (int i = 31; i >= 0; i--) if (pending[i]) v = i;
        bus.irq_req    = |pending;
        bus.irq_vector = VW'(v);
    endtask

    // One clock: reference model evaluated on this cycle's inputs, DUT advanced
    task automatic cycle();
        int top, vec;
        bit elig, acc, take_err, eoi_err;
        drive_ctrl();
        #1;
        vec  = int'(bus.irq_vector);
        top  = (m_q.size() > 0) ? m_q[$] : 0;
        elig = bus.global_en && bus.irq_req && (m_q.size() < ND) && (m_q.size() == 0 || vec < top);
        acc  = rst_n && m_offer && elig && (vec == m_vec) && bus.core_take;
        exp_ack = acc;
        obs_ack = bus.irq_ack;
        if (!rst_n) begin
            m_offer = 0; m_vec = 0; m_q.delete(); m_err = 2'b00;
        end else begin
            take_err = bus.core_take && !(m_offer && elig);
            eoi_err  = bus.core_eoi && (m_q.size() == 0);
            m_err = bus.err_clr ? {take_err, eoi_err} : (m_err | {take_err, eoi_err});
            if (bus.core_eoi && m_q.size() > 0) void'(m_q.pop_back());
            if (acc) m_q.push_back(m_vec);
            if (!m_offer) begin
                if (elig) begin m_offer = 1; m_vec = vec; end
            end else if (!elig) m_offer = 0;
            else if (vec != m_vec) m_vec = vec;
            else if (bus.core_take) m_offer = 0;
        end
        @(posedge clk);
        if (obs_ack) pending[vec] = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pending = '0;
        bus.global_en = 1'b0; bus.core_take = 1'b0; bus.core_eoi = 1'b0; bus.err_clr = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
    endtask

    task automatic push_vec(input int v);
        pending[v] = 1'b1;
        cycle();
        bus.core_take = 1'b1;
        cycle();
        bus.core_take = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0; bus.global_en = 1'b1; pending[3] = 1'b1; bus.core_take = 1'b1;
        cycle();
        checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", obs_ack); end
        checks++; if (bus.core_irq !== 1'b0) begin failures++; $display("FAIL reset_core_irq got=%0b exp=0", bus.core_irq); end
        checks++; if (bus.core_vector !== 5'd0) begin failures++; $display("FAIL reset_core_vector got=%0d exp=0", bus.core_vector); end
        checks++; if (bus.cur_vector !== 5'd0 || bus.in_service !== 1'b0) begin failures++; $display("FAIL reset_cur got=%0d/%0b exp=0/0", bus.cur_vector, bus.in_service); end
        checks++; if (bus.active_depth !== 4'd0 || bus.err_flags !== 2'b00) begin failures++; $display("FAIL reset_depth_err got=%0d/%b exp=0/00", bus.active_depth, bus.err_flags); end
        bus.core_take = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        bus.global_en = 1'b1; pending[7] = 1'b1;
        cycle();
        checks++; if (bus.core_irq !== 1'b1 || bus.core_vector !== 5'd7) begin failures++; $display("FAIL basic_offer got=%0b/%0d exp=1/7", bus.core_irq, bus.core_vector); end
        cycle(); cycle();
        bus.core_take = 1'b1;
        cycle();
        bus.core_take = 1'b0;
        checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL basic_ack got=%0b exp=1", obs_ack); end
        checks++; if (bus.core_irq !== 1'b0 || bus.cur_vector !== 5'd7 || bus.active_depth !== 4'd1) begin failures++; $display("FAIL basic_push got=%0b/%0d/%0d exp=0/7/1", bus.core_irq, bus.cur_vector, bus.active_depth); end
        bus.core_eoi = 1'b1;
        cycle();
        bus.core_eoi = 1'b0;
        checks++; if (bus.active_depth !== 4'd0 || bus.in_service !== 1'b0) begin failures++; $display("FAIL basic_eoi got=%0d/%0b exp=0/0", bus.active_depth, bus.in_service); end
    endtask

    task automatic test_nesting();
        do_reset();
        bus.global_en = 1'b1;
        push_vec(7);
        pending[3] = 1'b1;
        cycle();
        checks++; if (bus.core_irq !== 1'b1 || bus.core_vector !== 5'd3) begin failures++; $display("FAIL nest_offer got=%0b/%0d exp=1/3", bus.core_irq, bus.core_vector); end
        bus.core_take = 1'b1;
        cycle();
        bus.core_take = 1'b0;
        checks++; if (bus.active_depth !== 4'd2 || bus.cur_vector !== 5'd3) begin failures++; $display("FAIL nest_push got=%0d/%0d exp=2/3", bus.active_depth, bus.cur_vector); end
        pending[9] = 1'b1;
        cycle(); cycle();
        checks++; if (bus.core_irq !== 1'b0) begin failures++; $display("FAIL nest_lower_blocked got=%0b exp=0", bus.core_irq); end
        bus.core_eoi = 1'b1;
        cycle();
        checks++; if (bus.active_depth !== 4'd1 || bus.cur_vector !== 5'd7) begin failures++; $display("FAIL nest_eoi1 got=%0d/%0d exp=1/7", bus.active_depth, bus.cur_vector); end
        cycle();
        bus.core_eoi = 1'b0;
        checks++; if (bus.active_depth !== 4'd0 || bus.core_irq !== 1'b0) begin failures++; $display("FAIL nest_eoi2 got=%0d/%0b exp=0/0", bus.active_depth, bus.core_irq); end
        cycle();
        checks++; if (bus.core_irq !== 1'b1 || bus.core_vector !== 5'd9) begin failures++; $display("FAIL nest_late_offer got=%0b/%0d exp=1/9", bus.core_irq, bus.core_vector); end
    endtask

    task automatic test_retarget();
        do_reset();
        bus.global_en = 1'b1; pending[12] = 1'b1;
        cycle();
        pending[4] = 1'b1; bus.core_take = 1'b1;
        cycle();
        checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL retarget_no_ack got=%0b exp=0", obs_ack); end
        checks++; if (bus.core_irq !== 1'b1 || bus.core_vector !== 5'd4 || bus.err_flags !== 2'b00) begin failures++; $display("FAIL retarget_vec got=%0b/%0d/%b exp=1/4/00", bus.core_irq, bus.core_vector, bus.err_flags); end
        cycle();
        bus.core_take = 1'b0;
        checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL retarget_ack got=%0b exp=1", obs_ack); end
        checks++; if (bus.cur_vector !== 5'd4 || bus.active_depth !== 4'd1) begin failures++; $display("FAIL retarget_push got=%0d/%0d exp=4/1", bus.cur_vector, bus.active_depth); end
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.global_en = 1'b1; pending[5] = 1'b1;
        cycle();
        bus.global_en = 1'b0; bus.core_take = 1'b1;
        cycle();
        checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL withdraw_no_ack got=%0b exp=0", obs_ack); end
        checks++; if (bus.core_irq !== 1'b0 || bus.err_flags !== 2'b10 || bus.active_depth !== 4'd0) begin failures++; $display("FAIL withdraw_state got=%0b/%b/%0d exp=0/10/0", bus.core_irq, bus.err_flags, bus.active_depth); end
        bus.err_clr = 1'b1;
        cycle();
        checks++; if (bus.err_flags !== 2'b10) begin failures++; $display("FAIL err_set_wins got=%b exp=10", bus.err_flags); end
        bus.core_take = 1'b0;
        cycle();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_flags !== 2'b00) begin failures++; $display("FAIL err_clr got=%b exp=00", bus.err_flags); end
    endtask

    task automatic test_full();
        do_reset();
        bus.global_en = 1'b1;
        push_vec(20); push_vec(15); push_vec(10); push_vec(2);
        checks++; if (bus.active_depth !== 4'd4 || bus.cur_vector !== 5'd2) begin failures++; $display("FAIL full_fill got=%0d/%0d exp=4/2", bus.active_depth, bus.cur_vector); end
        pending[1] = 1'b1;
        cycle(); cycle();
        checks++; if (bus.core_irq !== 1'b0 || bus.active_depth !== 4'd4) begin failures++; $display("FAIL full_no_offer got=%0b/%0d exp=0/4", bus.core_irq, bus.active_depth); end
        pending = '0; bus.core_eoi = 1'b1;
        repeat (5) cycle();
        bus.core_eoi = 1'b0;
        checks++; if (bus.active_depth !== 4'd0 || bus.err_flags !== 2'b01 || bus.in_service !== 1'b0) begin failures++; $display("FAIL underflow got=%0d/%b/%0b exp=0/01/0", bus.active_depth, bus.err_flags, bus.in_service); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.global_en = 1'b1;
        push_vec(7);
        pending[3] = 1'b1;
        cycle();
        bus.core_take = 1'b1; bus.core_eoi = 1'b1;
        cycle();
        bus.core_take = 1'b0; bus.core_eoi = 1'b0;
        checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL simul_ack got=%0b exp=1", obs_ack); end
        checks++; if (bus.active_depth !== 4'd1 || bus.cur_vector !== 5'd3 || bus.err_flags !== 2'b00) begin failures++; $display("FAIL simul_replace got=%0d/%0d/%b exp=1/3/00", bus.active_depth, bus.cur_vector, bus.err_flags); end
        bus.core_eoi = 1'b1;
        cycle();
        bus.core_eoi = 1'b0; pending[9] = 1'b1;
        cycle();
        rst_n = 1'b0; bus.core_take = 1'b1;
        cycle();
        rst_n = 1'b1; bus.core_take = 1'b0;
        checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL midreset_ack got=%0b exp=0", obs_ack); end
        checks++; if (bus.core_irq !== 1'b0 || bus.core_vector !== 5'd0 || bus.cur_vector !== 5'd0 || bus.active_depth !== 4'd0 || bus.in_service !== 1'b0 || bus.err_flags !== 2'b00) begin
            failures++; $display("FAIL midreset_outputs got=%0b/%0d/%0d/%0d/%0b/%b exp=all zero", bus.core_irq, bus.core_vector, bus.cur_vector, bus.active_depth, bus.in_service, bus.err_flags);
        end
        cycle();
        checks++; if (bus.core_irq !== 1'b1 || bus.core_vector !== 5'd9) begin failures++; $display("FAIL midreset_reoffer got=%0b/%0d exp=1/9", bus.core_irq, bus.core_vector); end
    endtask

    task automatic test_random();
        int exp_cur;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bus.global_en = ($urandom_range(9) != 0);
            if ($urandom_range(2) == 0) pending[$urandom_range(31)] = 1'b1;
            if ($urandom_range(40) == 0) pending = '0;
            bus.core_take = ($urandom_range(1) == 1);
            bus.core_eoi  = ($urandom_range(5) == 0);
            bus.err_clr   = ($urandom_range(15) == 0);
            rst_n         = ($urandom_range(149) != 0);
            cycle();
            exp_cur = (m_q.size() > 0) ? m_q[$] : 0;
            checks++; if (obs_ack !== exp_ack) begin failures++; $display("FAIL rnd_ack n=%0d got=%0b exp=%0b", n, obs_ack, exp_ack); end
            checks++; if (bus.core_irq !== m_offer) begin failures++; $display("FAIL rnd_core_irq n=%0d got=%0b exp=%0b", n, bus.core_irq, m_offer); end
            if (m_offer) begin
                checks++; if (bus.core_vector !== VW'(m_vec)) begin failures++; $display("FAIL rnd_core_vector n=%0d got=%0d exp=%0d", n, bus.core_vector, m_vec); end
            end
            checks++; if (bus.active_depth !== 4'(m_q.size())) begin failures++; $display("FAIL rnd_depth n=%0d got=%0d exp=%0d", n, bus.active_depth, m_q.size()); end
            checks++; if (bus.cur_vector !== VW'(exp_cur) || bus.in_service !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_top n=%0d got=%0d/%0b exp=%0d/%0b", n, bus.cur_vector, bus.in_service, exp_cur, m_q.size() != 0); end
            checks++; if (bus.err_flags !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, bus.err_flags, m_err); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pending = '0;
        bus.global_en = 1'b0; bus.core_take = 1'b0; bus.core_eoi = 1'b0; bus.err_clr = 1'b0;
        drive_ctrl();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_nesting();
        test_retarget();
        test_withdraw();
        test_full();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
